// File: rtl/alu_issue.sv
// alu_issue: issue/write-back controller driving a registered ALU, one instruction per 3 cycles.
// Define ALU_ISSUE_IMM_EN to decode I-type addi/addiu/andi/ori/xori; otherwise they are illegal.
module alu_issue (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [5:0]  alu_func,
    input  logic [31:0] alu_result,
    output logic        wb_valid,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        illegal
);
    typedef enum logic [1:0] {IDLE, EXEC, RESULT, WB} state_t;
    state_t      state_q, state_d;
    logic [31:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, wb_data_q, wb_data_d;
    logic [5:0]  alu_func_q, alu_func_d;
    logic [4:0]  dest_q, dest_d, wb_addr_q, wb_addr_d;
    logic        wb_valid_q, wb_valid_d, illegal_q, illegal_d;
    logic        legal;
    logic [31:0] dec_a, dec_b;
    logic [5:0]  dec_func, opcode, funct;
    logic [4:0]  dec_dest;
    logic        unused_idx;
    assign opcode      = instr[31:26];
    assign funct       = instr[5:0];
    assign unused_idx  = ^instr[25:16];
    assign instr_ready = (state_q == IDLE) || (state_q == WB);
    always_comb begin
        legal    = 1'b0;
        dec_a    = rs_data;
        dec_b    = rt_data;
        dec_func = funct;
        dec_dest = instr[15:11];
        if (opcode == 6'd0) begin
            case (funct)
                6'h00, 6'h02, 6'h03: begin legal = 1'b1; dec_a = {27'b0, instr[10:6]}; end
                6'h04, 6'h06, 6'h07: begin legal = 1'b1; dec_a = {27'b0, rs_data[4:0]}; end
                6'h20, 6'h21:        begin legal = 1'b1; dec_func = 6'h20; end
                6'h22, 6'h23:        begin legal = 1'b1; dec_func = 6'h22; end
                6'h24, 6'h25, 6'h26, 6'h27: legal = 1'b1;
                default:             legal = 1'b0;
            endcase
`ifdef ALU_ISSUE_IMM_EN
        end else if (opcode == 6'd8 || opcode == 6'd9) begin
            legal    = 1'b1;
            dec_dest = instr[20:16];
            dec_b    = {{16{instr[15]}}, instr[15:0]};
            dec_func = 6'h20;
        end else if (opcode == 6'd12 || opcode == 6'd13 || opcode == 6'd14) begin
            legal    = 1'b1;
            dec_dest = instr[20:16];
            dec_b    = {16'b0, instr[15:0]};
            // andi/ori/xori map onto and/or/xor through the low opcode bits
            dec_func = {4'b1001, opcode[1:0]};
`endif
        end
    end
    always_comb begin
        state_d    = state_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_func_d = alu_func_q;
        dest_d     = dest_q;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        wb_valid_d = 1'b0;
        illegal_d  = 1'b0;
        case (state_q)
            EXEC:    state_d = RESULT;
            RESULT: begin
                state_d    = WB;
                wb_data_d  = alu_result;
                wb_addr_d  = dest_q;
                wb_valid_d = dest_q != 5'd0;
            end
            default: state_d = IDLE;
        endcase
        if (instr_valid && instr_ready) begin
            if (legal) begin
                state_d    = EXEC;
                alu_a_d    = dec_a;
                alu_b_d    = dec_b;
                alu_func_d = dec_func;
                dest_d     = dec_dest;
            end else begin
                illegal_d  = 1'b1;
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_func_q <= '0;
            dest_q     <= '0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            wb_valid_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_func_q <= alu_func_d;
            dest_q     <= dest_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
            wb_valid_q <= wb_valid_d;
            illegal_q  <= illegal_d;
        end
    end
    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign alu_func = alu_func_q;
    assign wb_valid = wb_valid_q;
    assign wb_addr  = wb_addr_q;
    assign wb_data  = wb_data_q;
    assign illegal  = illegal_q;
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed vectors for alu_issue against a registered ALU model.
module tb_alu_issue;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [31:0] instr = '0, rs_data = '0, rt_data = '0;
    logic [31:0] alu_a, alu_b, alu_result = '0, wb_data;
    logic [5:0]  alu_func;
    logic        wb_valid, illegal;
    logic [4:0]  wb_addr;
    int          n_checks = 0, n_fail = 0;

    alu_issue dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .rs_data(rs_data), .rt_data(rt_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func), .alu_result(alu_result),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .illegal(illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b, input logic [5:0] f);
        case (f)
            6'h00, 6'h04: return b << a[4:0];
            6'h02, 6'h06: return b >> a[4:0];
            6'h03, 6'h07: return $unsigned($signed(b) >>> a[4:0]);
            6'h20:        return a + b;
            6'h22:        return a - b;
            6'h24:        return a & b;
            6'h25:        return a | b;
            6'h26:        return a ^ b;
            6'h27:        return ~(a | b);
            default:      return 32'hBAD0BAD0;
        endcase
    endfunction

    always @(posedge clk) alu_result <= alu_model(alu_a, alu_b, alu_func);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic run(input string tag, input logic [31:0] i, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] ea, input logic [31:0] eb, input logic [5:0] ef,
                       input logic ewb, input logic [4:0] eaddr, input logic [31:0] edata);
        @(negedge clk);
        check({tag, ".ready"}, 32'(instr_ready), 32'd1);
        instr = i; rs_data = rs; rt_data = rt; instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        check({tag, ".alu_a"}, alu_a, ea);
        check({tag, ".alu_b"}, alu_b, eb);
        check({tag, ".alu_func"}, 32'(alu_func), 32'(ef));
        check({tag, ".busy"}, 32'(instr_ready), 32'd0);
        @(negedge clk);
        check({tag, ".early_wb"}, 32'(wb_valid), 32'd0);
        @(negedge clk);
        check({tag, ".wb_valid"}, 32'(wb_valid), 32'(ewb));
        if (ewb) begin
            check({tag, ".wb_addr"}, 32'(wb_addr), 32'(eaddr));
            check({tag, ".wb_data"}, wb_data, edata);
        end
        @(negedge clk);
        check({tag, ".wb_drop"}, 32'(wb_valid), 32'd0);
    endtask

    task automatic run_illegal(input string tag, input logic [31:0] i,
                               input logic [31:0] ea, input logic [31:0] eb, input logic [5:0] ef);
        @(negedge clk);
        instr = i; rs_data = 32'h1234_5678; rt_data = 32'h9ABC_DEF0; instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        check({tag, ".illegal"}, 32'(illegal), 32'd1);
        check({tag, ".ready"}, 32'(instr_ready), 32'd1);
        check({tag, ".alu_a"}, alu_a, ea);
        check({tag, ".alu_b"}, alu_b, eb);
        check({tag, ".alu_func"}, 32'(alu_func), 32'(ef));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check({tag, ".illegal_drop"}, 32'(illegal), 32'd0);
            check({tag, ".no_wb"}, 32'(wb_valid), 32'd0);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst.ready", 32'(instr_ready), 32'd1);
        check("rst.alu_a", alu_a, 32'd0);
        check("rst.alu_func", 32'(alu_func), 32'd0);
        check("rst.wb_valid", 32'(wb_valid), 32'd0);
        check("rst.illegal", 32'(illegal), 32'd0);
        rst_n = 1'b1;

        run("add",  32'h0022_1820, 32'd5, 32'd7, 32'd5, 32'd7, 6'h20, 1'b1, 5'd3, 32'd12);
        run("sll",  32'h0002_20C0, 32'hDEAD, 32'd1, 32'd3, 32'd1, 6'h00, 1'b1, 5'd4, 32'd8);
        run("srav", 32'h0022_3007, 32'h24, 32'h8000_0000, 32'd4, 32'h8000_0000, 6'h07, 1'b1, 5'd6, 32'hF800_0000);
        run("subu", 32'h0022_4023, 32'd10, 32'd3, 32'd10, 32'd3, 6'h22, 1'b1, 5'd8, 32'd7);
        run("nor",  32'h0022_4827, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'hF0F0_F0F0, 32'h0F0F_0000, 6'h27, 1'b1, 5'd9, 32'h0000_0F0F);
        run_illegal("op3f", 32'hFC00_0000, 32'hF0F0_F0F0, 32'h0F0F_0000, 6'h27);
        run_illegal("mult", 32'h0022_1818, 32'hF0F0_F0F0, 32'h0F0F_0000, 6'h27);
`ifdef ALU_ISSUE_IMM_EN
        run("addi", 32'h2025_FFFF, 32'd10, 32'h5555, 32'd10, 32'hFFFF_FFFF, 6'h20, 1'b1, 5'd5, 32'd9);
        run("ori",  32'h3426_8001, 32'h0000_0F00, 32'h5555, 32'h0000_0F00, 32'h0000_8001, 6'h25, 1'b1, 5'd6, 32'h0000_8F01);
`else
        run_illegal("addi", 32'h2025_FFFF, 32'hF0F0_F0F0, 32'h0F0F_0000, 6'h27);
`endif
        run("rd0", 32'h0022_0020, 32'd1, 32'd1, 32'd1, 32'd1, 6'h20, 1'b0, 5'd0, 32'd0);

        // back-to-back: second instruction accepted in the WB cycle of the first
        @(negedge clk);
        instr = 32'h0022_5020; rs_data = 32'd100; rt_data = 32'd23; instr_valid = 1'b1;
        @(negedge clk);
        check("b2b.a0", alu_a, 32'd100);
        instr = 32'h0022_5826; rs_data = 32'hFF00_FF00; rt_data = 32'h0FF0_0FF0;
        @(negedge clk);
        check("b2b.busy", 32'(instr_ready), 32'd0);
        @(negedge clk);
        check("b2b.wb0", 32'(wb_valid), 32'd1);
        check("b2b.addr0", 32'(wb_addr), 32'd10);
        check("b2b.data0", wb_data, 32'd123);
        check("b2b.ready_wb", 32'(instr_ready), 32'd1);
        @(negedge clk);
        instr_valid = 1'b0;
        check("b2b.a1", alu_a, 32'hFF00_FF00);
        check("b2b.func1", 32'(alu_func), 32'h26);
        check("b2b.gap0", 32'(wb_valid), 32'd0);
        @(negedge clk);
        check("b2b.gap1", 32'(wb_valid), 32'd0);
        @(negedge clk);
        check("b2b.wb1", 32'(wb_valid), 32'd1);
        check("b2b.addr1", 32'(wb_addr), 32'd11);
        check("b2b.data1", wb_data, 32'hF0F0_F0F0);
        @(negedge clk);
        check("b2b.drop", 32'(wb_valid), 32'd0);

        // asynchronous reset while the instruction sits in RESULT
        @(negedge clk);
        instr = 32'h0022_1820; rs_data = 32'd5; rt_data = 32'd7; instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst.ready", 32'(instr_ready), 32'd1);
        check("arst.alu_a", alu_a, 32'd0);
        check("arst.alu_b", alu_b, 32'd0);
        check("arst.alu_func", 32'(alu_func), 32'd0);
        check("arst.wb_addr", 32'(wb_addr), 32'd0);
        check("arst.wb_data", wb_data, 32'd0);
        check("arst.wb_valid", 32'(wb_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("arst.no_wb", 32'(wb_valid), 32'd0);
            check("arst.idle", 32'(instr_ready), 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
